// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared constants and per-lane event bundle for the key conditioner
package key_cond_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_REPEAT_DELAY    = 25000000;
  localparam int DEFAULT_REPEAT_PERIOD   = 5000000;

  typedef struct packed {
    logic held;
    logic press;
    logic released;
  } key_event_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_lane.sv
// key_lane: synchronizer, debounce and optional auto-repeat for one key (KEY_AUTOREPEAT_EN)
module key_lane
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
`endif
) (
  input  logic       i_clock,
  input  logic       i_reset_l,
  input  logic       i_key_l,
  output key_event_t o_event
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_held;
  logic          r_press;
  logic          r_release;
  logic          w_key;
  logic          w_diff;
  logic          w_accept;
  logic          w_rise;
  logic          w_fall;
  logic          w_repeat;

  assign w_key    = ~r_sync[1];
  assign w_diff   = w_key ^ r_held;
  assign w_accept = w_diff && (r_cnt == LAST);
  assign w_rise   = w_accept && !r_held;
  assign w_fall   = w_accept && r_held;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [RW-1:0] r_rpt;

  // a repeat is due when the countdown expires on a key that stays down
  assign w_repeat = r_held && !w_fall && (r_rpt == '0);

  // countdown to the next repeat: delay after the first press, period after each repeat
  always_ff @(posedge i_clock or negedge i_reset_l)
    if (!i_reset_l) r_rpt <= '0;
    else r_rpt <= w_fall ? '0 :
                  w_rise ? RW'(REPEAT_DELAY - 1) :
                  w_repeat ? RW'(REPEAT_PERIOD - 1) :
                  (r_rpt != '0) ? r_rpt - 1'b1 : r_rpt;
`else
  assign w_repeat = 1'b0;
`endif

  // two-flop synchronizer; resets to the released (high) pin level
  always_ff @(posedge i_clock or negedge i_reset_l)
    if (!i_reset_l) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], i_key_l};

  // debounce: any agreement with held restarts the count, a full run toggles held
  always_ff @(posedge i_clock or negedge i_reset_l)
    if (!i_reset_l) begin
      r_cnt     <= '0;
      r_held    <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_cnt     <= (w_diff && !w_accept) ? r_cnt + 1'b1 : '0;
      r_held    <= r_held ^ w_accept;
      r_press   <= w_rise || w_repeat;
      r_release <= w_fall;
    end

  assign o_event = '{held: r_held, press: r_press, released: r_release};

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounced level and press/release pulses for NUM_KEYS active-low buttons (KEY_AUTOREPEAT_EN)
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
`endif
) (
  input  logic                i_clock,
  input  logic                i_reset_l,
  input  logic [NUM_KEYS-1:0] i_key_l,
  output logic [NUM_KEYS-1:0] o_held,
  output logic [NUM_KEYS-1:0] o_press,
  output logic [NUM_KEYS-1:0] o_release
);

  key_event_t w_ev [NUM_KEYS];

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_lane (
      .i_clock  (i_clock),
      .i_reset_l(i_reset_l),
      .i_key_l  (i_key_l[i]),
      .o_event  (w_ev[i])
    );
    assign o_held[i]    = w_ev[i].held;
    assign o_press[i]   = w_ev[i].press;
    assign o_release[i] = w_ev[i].released;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce latency, glitch rejection, reset and auto-repeat
module tb_key_conditioner;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] held;
  logic [3:0] press;
  logic [3:0] rel;
  int         n_chk = 0;
  int         n_bad = 0;
  int         np;
  int         nr;

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(4)
`ifdef KEY_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
`endif
  ) dut (
    .i_clock  (clk),
    .i_reset_l(rst_n),
    .i_key_l  (key),
    .o_held   (held),
    .o_press  (press),
    .o_release(rel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 4'hF;
    repeat (3) tick();
    check("reset_state", {held, press, rel}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle", {held, press, rel}, 0);
    end
    key = 4'b0111;
    for (int e = 0; e <= 30; e++) begin
      if (e == 20) key = 4'hF;
      tick();
      check("k3_held", held[3], e >= 5 && e < 25);
      check("k3_press", press[3], e == 5 || (AR && e >= 15 && e < 25 && (e - 15) % 3 == 0));
      check("k3_rel", rel[3], e == 25);
      check("k3_others", {held[2:0], press[2:0], rel[2:0]}, 0);
    end
    for (int i = 0; i < 40; i++) begin
      key[0] = (i % 4 == 3);
      tick();
      check("bounce_quiet", {held[0], press[0]}, 0);
    end
    key = 4'hE;
    np  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      np += int'(press[0]);
    end
    check("bounce_press_once", np, 1);
    check("bounce_held", held[0], 1);
    key = 4'hF;
    np  = 0;
    nr  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      np += int'(press[0]);
      nr += int'(rel[0]);
    end
    check("k0_rel_once", nr, 1);
    check("k0_no_press_after", np, 0);
    check("k0_held_low", held[0], 0);
    key = 4'b1011;
    repeat (7) tick();
    check("k2_held_pre", held, 4'b0100);
    key = 4'b1001;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_async", {held, press, rel}, 0);
    tick();
    check("mid_rst_hold", {held, press, rel}, 0);
    rst_n = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      check("post_rst_press", press, (j == 6) ? 4'b0110 : 4'b0000);
      check("post_rst_held", held, (j >= 6) ? 4'b0110 : 4'b0000);
    end
    key = 4'hF;
    repeat (8) tick();
    check("post_rst_released", held, 0);
    key = 4'b1010;
    for (int e = 0; e <= 18; e++) begin
      if (e == 7) key = 4'b1011;
      if (e == 13) key = 4'hF;
      tick();
      if (e == 5) check("dual_press", press, 4'b0101);
      check("dual_p0", press[0], e == 5);
      check("dual_held", held, {1'b0, e >= 5 && e < 18, 1'b0, e >= 5 && e < 12});
      check("dual_rel", rel, {1'b0, e == 18, 1'b0, e == 12});
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input-side front end for the board's pushbuttons. It synchronizes the raw active-low KEY inputs, debounces each one, and emits clean active-high level and single-cycle press/release pulses. The game core consumes these pulses for its enter and new-game strobes. It sits between the chip-level pins and the game logic, replacing the bare single-flop key capture.

## Interface
- NUM_KEYS, 4: number of independent key lanes.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a change (10 ms at 50 MHz). Must be ≥ 2.
- REPEAT_DELAY, 25000000: cycles from a press pulse to the first auto-repeat pulse. Used only with KEY_AUTOREPEAT_EN. Must be ≥ 2.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat pulses. Used only with KEY_AUTOREPEAT_EN. Must be ≥ 2.
- clock  input  1  system clock (CLOCK_50 at top level).
- reset_L  input  1  asynchronous, active-low reset.
- key_L  input  NUM_KEYS  raw pushbuttons, active-low, asynchronous to clock.
- held  output  NUM_KEYS  debounced level, 1 = key pressed.
- press  output  NUM_KEYS  one-cycle pulse when a press is accepted (and on auto-repeat).
- release  output  NUM_KEYS  one-cycle pulse when a release is accepted.

## Operation
- Each lane is fully independent; there is no cross-lane interaction.
- Two-flop synchronizer per lane, inverted to active-high. The synchronizer flops reset to the "released" state.
- Debounce counter per lane, width $clog2(DEBOUNCE_CYCLES). On each edge:
  - If the synchronized value equals held, the counter clears.
  - If the synchronized value differs from held and count < DEBOUNCE_CYCLES-1, the counter increments.
  - If the synchronized value differs from held and count == DEBOUNCE_CYCLES-1, held toggles and the counter clears.
- Any single-cycle agreement with held during counting restarts the count from 0 (glitch rejection).
- press is asserted on the same edge that held goes 0→1. release is asserted on the same edge that held goes 1→0.
- press and release are never asserted together on one lane.
- All outputs are registered.
- Reset (asynchronous assert, any time, including mid-count): synchronizers = released; held, press, release, all counters = 0.
- A key that is still down when reset_L deasserts is treated as a new press: press fires after the normal debounce latency.

## Timing
- If key_L[i] is held steady at 0 from before edge k, held[i] rises at edge k+1+DEBOUNCE_CYCLES.
  - Edges k and k+1 are the synchronizer edges.
  - Edges k+2 … k+1+DEBOUNCE_CYCLES are the counting edges.
  - press[i] is high for exactly that one cycle.
- Release uses the same latency, with release[i] pulsing.
- A bounce shorter than DEBOUNCE_CYCLES consecutive cycles produces no output change.
- Minimum spacing between accepted edges on a lane is DEBOUNCE_CYCLES cycles.

## Configuration
- KEY_AUTOREPEAT_EN defined: each lane has a repeat counter, width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - The counter loads on every press pulse.
  - While held stays 1, a further press pulse occurs REPEAT_DELAY cycles after the initial press, then every REPEAT_PERIOD cycles.
  - held falling clears the counter immediately; no repeat pulse follows a release.
  - Reset clears the counter.
- KEY_AUTOREPEAT_EN undefined: press fires only on a 0→1 transition of held. No repeat logic is synthesized and the REPEAT_* parameters are ignored.

## Structure
- Package key_cond_pkg holds:
  - Default constants: DEFAULT_DEBOUNCE_CYCLES, DEFAULT_REPEAT_DELAY, DEFAULT_REPEAT_PERIOD.
  - Typedef key_event_t (struct packed: held, press, release) for per-lane bundling.
- One sub-module, key_lane: synchronizer, debounce counter, and (conditionally) repeat counter for a single key.
- key_conditioner instantiates NUM_KEYS copies of key_lane in a generate loop.

## Test plan
Unless stated otherwise, benches use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset, then key_L=4'b1111 for 20 cycles → held, press, release all 0 throughout.
- key_L[3] driven 0 before edge 0 and held low → held[3]=1 and press[3]=1 at edge 5; press[3]=0 at edge 6. Then key_L[3]=1 before edge 20 → release[3] at edge 25.
- Bounce on key_L[0]: low 3 cycles, high 1 cycle, low 3 cycles, repeat for 40 cycles → no press[0] and held[0]=0. Then a steady low → press[0] exactly once.
- Key 1 pressed and reset_L pulsed low mid-count (edge 3) → all outputs 0 immediately. After reset_L deasserts with the key still down → press[1] DEBOUNCE_CYCLES+2 edges later.
- Keys 0 and 2 pressed simultaneously → both press pulses on the same edge, and each releases independently.
- With KEY_AUTOREPEAT_EN, key_L[0] held low → press[0] at edges 5, 15, 18, 21 …. Release → no further pulses after held[0] falls.
